// File: rtl/data_mem_responder.sv
// Data-side memory responder: word RAM with byte-masked writes, MMIO window
// (TX FIFO, status, 64-bit cycle counter) and an idle-cycle host port.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [29:0] MMIO_BASE   = 30'h3FFFFFFC,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        async_rst_n,
  input  logic        clk_en,
  input  logic        bus_lock,
  input  logic        memory_mode,
  input  logic [29:0] data_address,
  input  logic [3:0]  data_mask,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [29:0] host_addr,
  input  logic [31:0] host_wdata,
  input  logic [3:0]  host_mask,
  output logic        host_ack,
  output logic [31:0] host_rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {H_IDLE, H_ACCESS, H_ACK} host_state_e;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];

  host_state_e   state_q, state_d;
  logic [31:0]   data_out_q, data_out_d;
  logic [31:0]   host_rdata_q, host_rdata_d;
  logic          host_ack_q, host_ack_d;
  logic [AW-1:0] hst_addr_q, hst_addr_d;
  logic          hst_we_q, hst_we_d;
  logic [31:0]   hst_wdata_q, hst_wdata_d;
  logic [3:0]    hst_mask_q, hst_mask_d;
  logic [63:0]   cnt_q, cnt_d;
  logic [31:0]   snap_q, snap_d;
  logic          ovf_q, ovf_d;
  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  logic          is_mmio, core_wr, host_op;
  logic [29:0]   mmio_off;
  logic [31:0]   mmio_rdata, ram_rdata, ram_wdata;
  logic [AW-1:0] ram_idx;
  logic          ram_we;
  logic [3:0]    ram_mask;
  logic          empty, full, pop, push_req, push, ovf_set, ovf_clr;
  logic          unused_bits;

  assign unused_bits = ^{host_addr[29:AW], mmio_off[29:2]};

  always_comb begin
    is_mmio  = data_address >= MMIO_BASE;
    mmio_off = data_address - MMIO_BASE;
    core_wr  = clk_en && memory_mode;
    host_op  = (state_q == H_ACCESS) && !clk_en && !bus_lock;

    // Single RAM port: the core owns it whenever clk_en is high.
    ram_idx   = clk_en ? data_address[AW-1:0] : hst_addr_q;
    ram_rdata = mem[ram_idx];
    ram_we    = clk_en ? (core_wr && !is_mmio) : (host_op && hst_we_q);
    ram_wdata = clk_en ? data_in : hst_wdata_q;
    ram_mask  = clk_en ? data_mask : hst_mask_q;

    empty    = count_q == '0;
    full     = count_q == (PW+1)'(FIFO_DEPTH);
    pop      = !empty && tx_ready;
    push_req = core_wr && is_mmio && (mmio_off[1:0] == 2'd0) && data_mask[0];
    push     = push_req && (!full || pop);
    ovf_set  = push_req && full && !pop;
    ovf_clr  = core_wr && is_mmio && (mmio_off[1:0] == 2'd1) && data_mask[0] && data_in[0];

    case (mmio_off[1:0])
      2'd0:    mmio_rdata = 32'(count_q);
      2'd1:    mmio_rdata = {29'b0, ovf_q, full, empty};
      2'd2:    mmio_rdata = cnt_q[31:0];
      default: mmio_rdata = snap_q;
    endcase

    data_out_d = data_out_q;
    if (clk_en) data_out_d = is_mmio ? mmio_rdata : ram_rdata;

    cnt_d  = cnt_q + 64'd1;
    snap_d = snap_q;
    if (clk_en && !memory_mode && is_mmio && (mmio_off[1:0] == 2'd2)) snap_d = cnt_q[63:32];

    ovf_d    = (ovf_q && !ovf_clr) || ovf_set;
    count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);

    state_d      = state_q;
    host_ack_d   = 1'b0;
    host_rdata_d = host_rdata_q;
    hst_addr_d   = hst_addr_q;
    hst_we_d     = hst_we_q;
    hst_wdata_d  = hst_wdata_q;
    hst_mask_d   = hst_mask_q;
    case (state_q)
      H_ACCESS: begin
        // Held here until a cycle free of clk_en and bus_lock.
        if (host_op) begin
          state_d      = H_ACK;
          host_ack_d   = 1'b1;
          host_rdata_d = ram_rdata;
        end
      end
      default: begin
        state_d = H_IDLE;
        if (host_req && !clk_en && !bus_lock) begin
          state_d     = H_ACCESS;
          hst_addr_d  = host_addr[AW-1:0];
          hst_we_d    = host_we;
          hst_wdata_d = host_wdata;
          hst_mask_d  = host_mask;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q      <= H_IDLE;
      data_out_q   <= '0;
      host_rdata_q <= '0;
      host_ack_q   <= 1'b0;
      hst_addr_q   <= '0;
      hst_we_q     <= 1'b0;
      hst_wdata_q  <= '0;
      hst_mask_q   <= '0;
      cnt_q        <= '0;
      snap_q       <= '0;
      ovf_q        <= 1'b0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      data_out_q   <= data_out_d;
      host_rdata_q <= host_rdata_d;
      host_ack_q   <= host_ack_d;
      hst_addr_q   <= hst_addr_d;
      hst_we_q     <= hst_we_d;
      hst_wdata_q  <= hst_wdata_d;
      hst_mask_q   <= hst_mask_d;
      cnt_q        <= cnt_d;
      snap_q       <= snap_d;
      ovf_q        <= ovf_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      if (push) fifo_q[wr_ptr_q] <= data_in[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (ram_mask[b]) mem[ram_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  assign data_out   = data_out_q;
  assign host_ack   = host_ack_q;
  assign host_rdata = host_rdata_q;
  assign tx_valid   = !empty;
  assign tx_data    = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder.
module tb_data_mem_responder;

  localparam logic [29:0] MB = 30'h3FFFFFFC;

  logic        clk;
  logic        async_rst_n;
  logic        clk_en;
  logic        bus_lock;
  logic        memory_mode;
  logic [29:0] data_address;
  logic [3:0]  data_mask;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        host_req;
  logic        host_we;
  logic [29:0] host_addr;
  logic [31:0] host_wdata;
  logic [3:0]  host_mask;
  logic        host_ack;
  logic [31:0] host_rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(
    .DEPTH_WORDS(4096),
    .MMIO_BASE(MB),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .async_rst_n(async_rst_n),
    .clk_en(clk_en),
    .bus_lock(bus_lock),
    .memory_mode(memory_mode),
    .data_address(data_address),
    .data_mask(data_mask),
    .data_in(data_in),
    .data_out(data_out),
    .host_req(host_req),
    .host_we(host_we),
    .host_addr(host_addr),
    .host_wdata(host_wdata),
    .host_mask(host_mask),
    .host_ack(host_ack),
    .host_rdata(host_rdata),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic core(input logic we, input logic [29:0] a, input logic [3:0] m, input logic [31:0] d);
    clk_en       = 1'b1;
    memory_mode  = we;
    data_address = a;
    data_mask    = m;
    data_in      = d;
    step();
    memory_mode  = 1'b0;
  endtask

  logic [7:0] exp_b [4];

  initial begin
    async_rst_n  = 1'b0;
    clk_en       = 1'b1;
    bus_lock     = 1'b0;
    memory_mode  = 1'b0;
    data_address = MB + 30'd2;
    data_mask    = 4'h0;
    data_in      = '0;
    host_req     = 1'b0;
    host_we      = 1'b0;
    host_addr    = '0;
    host_wdata   = '0;
    host_mask    = 4'h0;
    tx_ready     = 1'b0;

    repeat (2) step();
    check("rst_data_out", data_out, 32'h0);
    check("rst_host_ack", 32'(host_ack), 32'h0);
    check("rst_host_rdata", host_rdata, 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);

    // Cycle counter from reset: edge k after release captures k-1.
    @(negedge clk);
    async_rst_n = 1'b1;
    step();
    check("cyc_lo_first", data_out, 32'd0);
    repeat (10) step();
    check("cyc_lo_10", data_out, 32'd10);
    data_address = MB + 30'd3;
    step();
    check("cyc_hi_snap", data_out, 32'd0);

    // Byte-masked write, read-first, aliasing, clk_en=0 hold.
    core(1'b1, 30'd5, 4'hF, 32'hAABBCCDD);
    core(1'b1, 30'd5, 4'h5, 32'h11223344);
    check("read_first", data_out, 32'hAABBCCDD);
    core(1'b0, 30'd5, 4'h0, 32'h0);
    check("masked_write", data_out, 32'hAA22CC44);
    core(1'b0, 30'd5 + 30'd4096, 4'h0, 32'h0);
    check("ram_alias", data_out, 32'hAA22CC44);
    clk_en = 1'b0; memory_mode = 1'b1; data_address = 30'd5; data_mask = 4'hF; data_in = 32'h0;
    step();
    check("clk_en_hold", data_out, 32'hAA22CC44);
    memory_mode = 1'b0;
    core(1'b0, 30'd5, 4'h0, 32'h0);
    check("clk_en_no_write", data_out, 32'hAA22CC44);

    // FIFO overflow.
    core(1'b1, MB, 4'hE, 32'h77);
    core(1'b0, MB, 4'h0, 32'h0);
    check("no_push_mask0", data_out, 32'd0);
    core(1'b1, MB, 4'h1, 32'h41);
    check("tx_valid_push", 32'(tx_valid), 32'h1);
    check("tx_data_push", 32'(tx_data), 32'h41);
    for (int i = 1; i < 5; i++) core(1'b1, MB, 4'h1, 32'h41 + 32'(i));
    core(1'b0, MB, 4'h0, 32'h0);
    check("ovf_count", data_out, 32'd4);
    core(1'b0, MB + 30'd1, 4'h0, 32'h0);
    check("ovf_status", data_out, 32'h6);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("ovf_pop_byte", 32'(tx_data), 32'h41 + 32'(i));
      step();
    end
    tx_ready = 1'b0;
    check("ovf_drained", 32'(tx_valid), 32'h0);
    core(1'b1, MB + 30'd1, 4'h1, 32'h1);
    core(1'b0, MB + 30'd1, 4'h0, 32'h0);
    check("ovf_cleared", data_out, 32'h1);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 4; i++) core(1'b1, MB, 4'h1, 32'h50 + 32'(i));
    tx_ready = 1'b1;
    core(1'b1, MB, 4'h1, 32'h55);
    tx_ready = 1'b0;
    core(1'b0, MB + 30'd1, 4'h0, 32'h0);
    check("full_pp_status", data_out, 32'h2);
    core(1'b0, MB, 4'h0, 32'h0);
    check("full_pp_count", data_out, 32'd4);
    exp_b = '{8'h51, 8'h52, 8'h53, 8'h55};
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("full_pp_byte", 32'(tx_data), 32'(exp_b[i]));
      step();
    end
    tx_ready = 1'b0;
    check("full_pp_drained", 32'(tx_valid), 32'h0);

    // Counter carry across bit 32.
    clk_en = 1'b1; memory_mode = 1'b0; data_address = MB + 30'd2;
    force dut.cnt_q = 64'h0000_0000_FFFF_FFFE;
    @(negedge clk);
    release dut.cnt_q;
    step();
    check("carry_lo_pre", data_out, 32'hFFFFFFFE);
    data_address = MB + 30'd3;
    step();
    check("carry_hi_pre", data_out, 32'h0);
    data_address = MB + 30'd2;
    step();
    check("carry_lo_post", data_out, 32'h0);
    data_address = MB + 30'd3;
    step();
    check("carry_hi_post", data_out, 32'h1);

    // Host arbitration.
    core(1'b1, 30'd9, 4'hF, 32'hCAFEF00D);
    host_req = 1'b1; host_we = 1'b0; host_addr = 30'd9;
    clk_en = 1'b1; data_address = 30'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("host_blk_clken", 32'(host_ack), 32'h0);
    end
    clk_en = 1'b0; bus_lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("host_blk_lock", 32'(host_ack), 32'h0);
    end
    bus_lock = 1'b0;
    step();
    check("host_ack_early", 32'(host_ack), 32'h0);
    step();
    check("host_ack", 32'(host_ack), 32'h1);
    check("host_rdata", host_rdata, 32'hCAFEF00D);
    host_req = 1'b0;
    step();
    check("host_ack_pulse", 32'(host_ack), 32'h0);

    // Host write deferred by a core access arriving while in ACCESS.
    host_req = 1'b1; host_we = 1'b1; host_addr = 30'd9;
    host_wdata = 32'h12345678; host_mask = 4'h3;
    step();
    check("hw_ack_e1", 32'(host_ack), 32'h0);
    clk_en = 1'b1; data_address = 30'd9; memory_mode = 1'b0;
    step();
    check("hw_core_prio", data_out, 32'hCAFEF00D);
    check("hw_deferred", 32'(host_ack), 32'h0);
    clk_en = 1'b0;
    step();
    check("hw_ack", 32'(host_ack), 32'h1);
    check("hw_rdata_pre", host_rdata, 32'hCAFEF00D);
    host_req = 1'b0;
    step();
    core(1'b0, 30'd9, 4'h0, 32'h0);
    check("hw_result", data_out, 32'hCAFE5678);

    // Reset during a pending host write with 3 bytes queued.
    for (int i = 0; i < 3; i++) core(1'b1, MB, 4'h1, 32'h61 + 32'(i));
    core(1'b0, 30'd9, 4'h0, 32'h0);
    clk_en = 1'b0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 30'd9;
    host_wdata = 32'hFFFFFFFF; host_mask = 4'hF;
    step();
    host_req = 1'b0;
    #3 async_rst_n = 1'b0;
    #1;
    check("mid_rst_data_out", data_out, 32'h0);
    check("mid_rst_tx_valid", 32'(tx_valid), 32'h0);
    check("mid_rst_tx_data", 32'(tx_data), 32'h0);
    check("mid_rst_host_ack", 32'(host_ack), 32'h0);
    check("mid_rst_host_rdata", host_rdata, 32'h0);
    repeat (2) step();
    @(negedge clk);
    async_rst_n = 1'b1;
    core(1'b0, 30'd9, 4'h0, 32'h0);
    check("mid_rst_ram", data_out, 32'hCAFE5678);
    core(1'b0, MB, 4'h0, 32'h0);
    check("mid_rst_count", data_out, 32'd0);
    core(1'b0, MB + 30'd1, 4'h0, 32'h0);
    check("mid_rst_status", data_out, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-side responder for the core's data memory port. Holds a word-addressed on-chip RAM with byte-masked writes, plus a small MMIO window with a byte TX FIFO and a 64-bit cycle counter. Returns read data registered one cycle after the address, which is when the writeback stage samples it. A secondary host port (loader/debug) reaches the RAM only in cycles the core leaves free, and never while the core holds `bus_lock`.

## Interface
Parameters:
- DEPTH_WORDS, 4096, RAM size in 32-bit words (power of two)
- MMIO_BASE, 30'h3FFFFFFC, word address of the first MMIO register (4 registers)
- FIFO_DEPTH, 4, TX FIFO entries (power of two)

Ports:
- clk  in  1  single clock; the one clock for this block
- async_rst_n  in  1  reset, asynchronous, active-low
- clk_en  in  1  core clock enable; same signal the core uses
- bus_lock  in  1  core lock; blocks host-port service
- memory_mode  in  1  1 = write, 0 = read
- data_address  in  30  core word address
- data_mask  in  4  byte-lane write enables; lane i = bits 8i+7:8i (little endian)
- data_in  in  32  core write data
- data_out  out  32  read data to core, registered
- host_req / host_we  in  1 / 1  host request / host write
- host_addr  in  30  host word address (RAM only)
- host_wdata / host_mask  in  32 / 4  host write data / lanes
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  32  host read data, valid with host_ack
- tx_valid / tx_data  out  1 / 8  FIFO head valid / byte
- tx_ready  in  1  consumer pop

## Operation
- Core access happens every cycle with clk_en=1. In cycles with clk_en=0, core writes are ignored and data_out holds.
- Decode: data_address >= MMIO_BASE selects MMIO, register offset = data_address - MMIO_BASE. Anything else selects RAM at index data_address[log2(DEPTH_WORDS)-1:0]; upper bits alias.
- RAM read: full word regardless of mask. RAM write: only masked lanes change. data_out on a write cycle = the pre-write word (read-first).
- MMIO offset 0 TXDATA: a write with mask[0]=1 pushes data_in[7:0]. If the FIFO is full and there is no same-cycle pop, the byte is dropped and sticky overflow is set. Read = {29'b0, count[2:0]}, with the count zero-extended.
- MMIO offset 1 STATUS: read = {29'b0, overflow, full, empty}. A write with mask[0]=1 and data_in[0]=1 clears overflow. A clear and a new overflow in the same cycle leaves overflow set.
- MMIO offset 2 CYCLE_LO: read returns counter[31:0] and snapshots counter[63:32]. Offset 3 CYCLE_HI: read returns the snapshot.
  - The counter is free-running, increments every clk whether or not clk_en is set, and wraps at 2^64.
  - Writes to offsets 2 and 3 are ignored.
- TX FIFO:
  - tx_valid = !empty; tx_data = head byte.
  - Pop on tx_valid && tx_ready.
  - Push and pop in the same cycle are both accepted, including when the FIFO is full.
  - Pointers wrap modulo FIFO_DEPTH.
- Host FSM:
  - IDLE: moves to ACCESS when host_req && !clk_en && !bus_lock. In ACCESS, the RAM operation runs that cycle (read-first).
  - ACCESS: moves to ACK next cycle, with host_ack=1 and host_rdata = word read.
  - ACK: returns to IDLE. If host_req is still high there, a new access starts under the IDLE rules.
  - If clk_en or bus_lock rises while the FSM is in ACCESS, the host access still completes. The core access that cycle takes priority, and the host operation is deferred one cycle and held in ACCESS.
- Reset (async assert, sync release): data_out=0, host_ack=0, host_rdata=0, tx_valid=0, tx_data=0, counter=0, snapshot=0, overflow=0, FIFO empty, FSM=IDLE. RAM contents are not reset.

## Timing
- Core read latency: address at edge N → data_out valid after edge N+1, held until the next clk_en cycle.
- Core write at edge N → a read of the same address at N+1 returns the new data.
- FIFO push at edge N → tx_valid high after N (when the FIFO was empty). Status and count reflect the push on the next read.
- Host latency: minimum 2 cycles from req sampled to host_ack. Unbounded while clk_en=1 or bus_lock=1.
- No combinational path from any input to any output except tx_data/tx_valid, which are register outputs only.

## Test plan
- Byte-masked write then read: write 0xAABBCCDD to word 5 with mask 4'b1111, then 0x11223344 with mask 4'b0101; the read of word 5 next cycle → 0xAA22CC44.
- FIFO overflow: tx_ready=0, push 0x41..0x45 → count reads 4, STATUS=3'b110 (overflow, full). Pop all → bytes 0x41..0x44 in order. Write STATUS with 1 → STATUS=3'b001.
- Full push+pop: FIFO full, push 0x55 with tx_ready=1 the same cycle → overflow stays 0, count stays 4, 0x55 is last out.
- Cycle counter: after reset, read CYCLE_LO at cycle 10 → 10 (±fixed pipeline offset, checked exactly). Preload the counter near 2^32 via force, read LO then HI → consistent 64-bit value across the carry.
- Host arbitration: host_req with clk_en=1 for 5 cycles → no ack. Drop clk_en with bus_lock=1 → no ack. Drop bus_lock → ack 2 cycles later, with host_rdata matching RAM.
- Reset mid-operation: assert async_rst_n low while in ACCESS with the FIFO holding 3 bytes → outputs zero immediately, FIFO empty, RAM word unchanged by the aborted host write.
